inst_legal_chk: RTL

Registered instruction-legality stage between IFU and IDU. It accepts fetched instructions over a valid/ready handshake and classifies each against the configured ISA (RV32I/RV64I, optional M, Zicsr, ecall/ebreak/mret). It forwards each instruction with an illegal flag, and raises a held trap request to the CSR unit on the first illegal instruction handed downstream. This block is the parametrised successor of the combinational unknown-opcode check; it adds XLEN/M-extension configurability, pipelining, trap capture and an illegal-instruction counter.

---
 rtl/legal_chk_pkg.sv | 40 ++++
 rtl/legal_decode.sv | 83 ++++++++
 rtl/inst_legal_chk.sv | 112 +++++++++++
 3 files changed

// File: rtl/legal_chk_pkg.sv
// Shared definitions for the instruction-legality stage: RV opcodes, funct7 codes,
// SYSTEM immediates and the trap FSM state type.
package legal_chk_pkg;

    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [6:0] F7_MUL  = 7'h01;

    // inst[31:7] of the privileged SYSTEM encodings with funct3 = 0
    localparam logic [24:0] SYS_ECALL  = 25'h0000000;
    localparam logic [24:0] SYS_EBREAK = 25'h0002000;
    localparam logic [24:0] SYS_MRET   = 25'h0604000;

    typedef enum logic {
        RUN       = 1'b0,
        TRAP_WAIT = 1'b1
    } state_e;

    // Immediate shifts: with a 6-bit shamt, inst[25] is shamt[5] and not part of funct7.
    function automatic logic imm_shift_ok(input logic [6:0] f7, input logic wide_shamt,
                                          input logic alt_ok);
        logic [6:0] hi;
        hi = wide_shamt ? {f7[6:1], 1'b0} : f7;
        return (hi == F7_BASE) || (alt_ok && (hi == F7_ALT));
    endfunction

endpackage

// File: rtl/legal_decode.sv
// Combinational legality classifier for one 32-bit instruction word against
// RV32I/RV64I, optional M, Zicsr and ecall/ebreak/mret.
module legal_decode #(
    parameter int XLEN  = 64,
    parameter int M_EXT = 1
) (
    input  logic [31:0] inst,
    output logic        illegal
);
    import legal_chk_pkg::*;

    localparam bit RV64  = (XLEN == 64);
    localparam bit M_ON  = (M_EXT != 0);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];

    // opcode includes inst[1:0], so compressed encodings fall into the default arm
    always_comb begin
        legal = 1'b0;
        case (opcode)
            LUI, AUIPC, JAL: legal = 1'b1;
            JALR:            legal = (f3 == 3'd0);
            BRANCH:          legal = (f3 != 3'd2) && (f3 != 3'd3);
            LOAD: begin
                case (f3)
                    3'd0, 3'd1, 3'd2, 3'd4, 3'd5: legal = 1'b1;
                    3'd3, 3'd6:                   legal = RV64;
                    default:                      legal = 1'b0;
                endcase
            end
            STORE:           legal = (f3 <= 3'd2) || ((f3 == 3'd3) && RV64);
            OP_IMM: begin
                case (f3)
                    3'd1:    legal = imm_shift_ok(f7, RV64, 1'b0);
                    3'd5:    legal = imm_shift_ok(f7, RV64, 1'b1);
                    default: legal = 1'b1;
                endcase
            end
            OP: begin
                case (f7)
                    F7_BASE: legal = 1'b1;
                    F7_ALT:  legal = (f3 == 3'd0) || (f3 == 3'd5);
                    F7_MUL:  legal = M_ON;
                    default: legal = 1'b0;
                endcase
            end
            OP_IMM_32: begin
                case (f3)
                    3'd0:    legal = RV64;
                    3'd1:    legal = RV64 && (f7 == F7_BASE);
                    3'd5:    legal = RV64 && ((f7 == F7_BASE) || (f7 == F7_ALT));
                    default: legal = 1'b0;
                endcase
            end
            OP_32: begin
                case (f7)
                    F7_BASE: legal = RV64 && ((f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd5));
                    F7_ALT:  legal = RV64 && ((f3 == 3'd0) || (f3 == 3'd5));
                    F7_MUL:  legal = RV64 && M_ON && (f3 != 3'd1) && (f3 != 3'd2) && (f3 != 3'd3);
                    default: legal = 1'b0;
                endcase
            end
            SYSTEM: begin
                if (f3 == 3'd0)
                    legal = (inst[31:7] == SYS_ECALL) || (inst[31:7] == SYS_EBREAK) ||
                            (inst[31:7] == SYS_MRET);
                else
                    legal = (f3 != 3'd4);
            end
            default: legal = 1'b0;
        endcase
    end

    assign illegal = ~legal;

endmodule

// File: rtl/inst_legal_chk.sv
// Registered IFU->IDU legality stage with illegal-instruction trap capture.
// Define LEGAL_CHK_CNT_EN to build the saturating illegal_cnt output.
module inst_legal_chk #(
    parameter int XLEN  = 64,
    parameter int M_EXT = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal,
    input  logic             flush,
    output logic             trap_req,
    input  logic             trap_ack,
    output logic [31:0]      trap_tval,
    output logic [XLEN-1:0]  trap_epc
`ifdef LEGAL_CHK_CNT_EN
    ,
    output logic [CNT_W-1:0] illegal_cnt
`endif
);
    import legal_chk_pkg::*;

    // Handshake: a beat moves on a rising edge where valid && ready. Upstream may only
    // rely on in_ready combinationally; out_* hold while out_valid && !out_ready.
    state_e state;
    logic   accept;
    logic   handoff;
    logic   cls_illegal;

    assign in_ready = rst_n && !flush && (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid && out_ready;

    legal_decode #(
        .XLEN  (XLEN),
        .M_EXT (M_EXT)
    ) u_decode (
        .inst    (in_inst),
        .illegal (cls_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_inst    <= '0;
            out_pc      <= '0;
            out_illegal <= 1'b0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (accept)
                out_valid <= 1'b1;
            else if (handoff)
                out_valid <= 1'b0;

            if (accept) begin
                out_inst    <= in_inst;
                out_pc      <= in_pc;
                out_illegal <= cls_illegal;
            end
        end
    end

    // A handoff in the flush cycle has already left the stage, so its trap is still taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            trap_req  <= 1'b0;
            trap_tval <= '0;
            trap_epc  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (handoff && out_illegal) begin
                        state     <= TRAP_WAIT;
                        trap_req  <= 1'b1;
                        trap_tval <= out_inst;
                        trap_epc  <= out_pc;
                    end
                end
                TRAP_WAIT: begin
                    if (trap_ack) begin
                        state    <= RUN;
                        trap_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    trap_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef LEGAL_CHK_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_cnt <= '0;
        else if (handoff && out_illegal && (illegal_cnt != {CNT_W{1'b1}}))
            illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
`endif

endmodule
